// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the M1->M2 memory access stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // result_src encodings seen by the memory stage
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;

    // access size codes taken from funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_RSP
    } state_e;

    // The unused 2'b11 code behaves as a word access.
    function automatic logic [1:0] size_norm(input logic [1:0] code);
        return (code == 2'b11) ? SZ_WORD : code;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data memory request/response bundle between the memory stage and the memory.
// Latency: n/a (wires only).
// Backpressure: request held by master until req_ready; response is not backpressured.
interface mem_access_unit_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half of a load response word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the lane addressed by the low address bits
    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // extend to 32 bits according to size and signedness
    always_comb begin
        case (size)
            SZ_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            SZ_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M1->M2 memory stage: issues aligned loads/stores to data memory and registers the M2 stage.
// Latency: non-memory 1 cycle, store >=1 cycle, load >=2 cycles (request + response).
// Backpressure: stall_m1 held while waiting for req_ready or the load response; bubbles go to M2.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reg_write_m1,
    input  logic                    mem_write_m1,
    input  logic [1:0]              result_src_m1,
    input  logic [2:0]              funct3_m1,
    input  logic [31:0]             alu_result_m1,
    input  logic [31:0]             write_data_m1,
    input  logic [31:0]             pc_plus4_m1,
    input  logic [4:0]              rd_m1,
    mem_access_unit_if.master       dmem,
    output logic                    stall_m1,
    output logic                    misalign_err,
    output logic                    reg_write_m2,
    output logic [1:0]              result_src_m2,
    output logic [31:0]             alu_result_m2,
    output logic [31:0]             read_data_m2,
    output logic [4:0]              rd_m2,
    output logic [31:0]             pc_plus4_m2
);

    state_e      state;
    state_e      state_nxt;
    logic        is_load;
    logic        mem_op;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        misaligned;
    logic        req_vld;
    logic        complete;
    logic        misalign_now;
    logic        load_done;
    logic [31:0] store_dat;
    logic [31:0] load_dat;

    assign is_load    = (result_src_m1 == RES_LOAD);
    assign mem_op     = is_load | mem_write_m1;
    assign size       = size_norm(funct3_m1[1:0]);
    assign off        = alu_result_m1[1:0];
    assign misaligned = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));

    // next state, request valid and completion of the M1 instruction
    always_comb begin
        state_nxt = state;
        req_vld   = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mem_op || misaligned) begin
                    complete = 1'b1;
                end else begin
                    req_vld = 1'b1;
                    if (dmem.dmem_req_ready) begin
                        if (is_load) begin
                            state_nxt = ST_WAIT_RSP;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (dmem.dmem_rsp_valid) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // store lane replication so the memory can pick lanes by byte enable alone
    always_comb begin
        case (size)
            SZ_BYTE: store_dat = {4{write_data_m1[7:0]}};
            SZ_HALF: store_dat = {2{write_data_m1[15:0]}};
            default: store_dat = write_data_m1;
        endcase
    end

    // reset drops the request in the same cycle it is asserted
    assign dmem.dmem_req_valid = req_vld & ~rst;
    assign dmem.dmem_req_we    = mem_write_m1;
    assign dmem.dmem_req_addr  = {alu_result_m1[31:2], 2'b00};
    assign dmem.dmem_req_wdata = store_dat;
    assign dmem.dmem_req_be    = byte_en(size, off);

    assign stall_m1     = mem_op & ~complete;
    assign misalign_now = (state == ST_IDLE) & mem_op & misaligned;
    assign load_done    = (state == ST_WAIT_RSP);

    load_extend u_load_extend (
        .rdata       (dmem.dmem_rsp_rdata),
        .off         (off),
        .size        (size),
        .is_unsigned (funct3_m1[2]),
        .data        (load_dat)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // M2 stage: completed instruction, or a bubble on every stall cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m2  <= 1'b0;
            result_src_m2 <= 2'b00;
            alu_result_m2 <= 32'h0;
            read_data_m2  <= 32'h0;
            rd_m2         <= 5'd0;
            pc_plus4_m2   <= 32'h0;
            misalign_err  <= 1'b0;
        end else if (complete) begin
            reg_write_m2  <= reg_write_m1 & ~misalign_now;
            result_src_m2 <= result_src_m1;
            alu_result_m2 <= alu_result_m1;
            read_data_m2  <= load_done ? load_dat : 32'h0;
            rd_m2         <= rd_m1;
            pc_plus4_m2   <= pc_plus4_m1;
            misalign_err  <= misalign_now;
        end else begin
            reg_write_m2  <= 1'b0;
            result_src_m2 <= 2'b00;
            alu_result_m2 <= 32'h0;
            read_data_m2  <= 32'h0;
            rd_m2         <= 5'd0;
            pc_plus4_m2   <= 32'h0;
            misalign_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset corner and random ops vs. a transaction model.
// Latency: n/a.
// Backpressure: bench drives req_ready/rsp_valid with per-op delays plus random noise.
module tb_mem_access_unit;

    typedef struct {
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [2:0]  funct3;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        int          ready_delay;
        int          rsp_delay;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        int          stall_cycles;
        logic        req;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] read_data;
        logic        err;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_m1, mem_write_m1;
    logic [1:0]  result_src_m1;
    logic [2:0]  funct3_m1;
    logic [31:0] alu_result_m1, write_data_m1, pc_plus4_m1;
    logic [4:0]  rd_m1;
    logic        stall_m1, misalign_err, reg_write_m2;
    logic [1:0]  result_src_m2;
    logic [31:0] alu_result_m2, read_data_m2, pc_plus4_m2;
    logic [4:0]  rd_m2;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit_if dif ();

    mem_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .reg_write_m1  (reg_write_m1),
        .mem_write_m1  (mem_write_m1),
        .result_src_m1 (result_src_m1),
        .funct3_m1     (funct3_m1),
        .alu_result_m1 (alu_result_m1),
        .write_data_m1 (write_data_m1),
        .pc_plus4_m1   (pc_plus4_m1),
        .rd_m1         (rd_m1),
        .dmem          (dif),
        .stall_m1      (stall_m1),
        .misalign_err  (misalign_err),
        .reg_write_m2  (reg_write_m2),
        .result_src_m2 (result_src_m2),
        .alu_result_m2 (alu_result_m2),
        .read_data_m2  (read_data_m2),
        .rd_m2         (rd_m2),
        .pc_plus4_m2   (pc_plus4_m2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(input logic rw, input logic mw, input logic [1:0] rs,
                               input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                               input int rdy, input int rsp, input logic [31:0] rdata);
        op_t o;
        o.reg_write = rw;  o.mem_write = mw;  o.result_src = rs;  o.funct3 = f3;
        o.alu = alu;  o.wdata = wd;  o.pc4 = alu + 32'h0000_1004;  o.rd = 5'd9;
        o.ready_delay = rdy;  o.rsp_delay = rsp;  o.rdata = rdata;
        return o;
    endfunction

    function automatic exp_t mke(input int st, input logic req, input logic [3:0] be,
                                 input logic [31:0] wd, input logic [31:0] addr,
                                 input logic [31:0] rdv, input logic err);
        exp_t e;
        e.stall_cycles = st;  e.req = req;  e.be = be;  e.wdata = wd;
        e.addr = addr;  e.read_data = rdv;  e.err = err;
        return e;
    endfunction

    // Transaction-level reference: what the op should do, derived from sizes in bytes.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          sz;
        int          o;
        longint unsigned mask;
        longint unsigned v;
        bit          is_load, mem, mis;
        sz      = (op.funct3[1:0] == 2'b00) ? 1 : (op.funct3[1:0] == 2'b01) ? 2 : 4;
        o       = int'(op.alu % 4);
        mis     = (o % sz) != 0;
        is_load = (op.result_src == 2'b01);
        mem     = is_load || op.mem_write;
        mask    = (64'd1 << (8 * sz)) - 1;
        e.err   = mem && mis;
        e.req   = mem && !mis;
        e.addr  = op.alu - 32'(o);
        e.be    = 4'(((1 << sz) - 1) << o);
        e.wdata = (sz == 1) ? (op.wdata & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (op.wdata & 32'hFFFF) * 32'h0001_0001 : op.wdata;
        v = (longint'(op.rdata) >> (8 * o)) & mask;
        if (!op.funct3[2] && sz < 4 && v[8*sz-1]) v = v | (~mask & 64'hFFFF_FFFF);
        e.read_data = (is_load && e.req) ? 32'(v) : 32'h0;
        if (!e.req)        e.stall_cycles = 0;
        else if (!is_load) e.stall_cycles = op.ready_delay;
        else               e.stall_cycles = op.ready_delay + 1 + op.rsp_delay;
        return e;
    endfunction

    task automatic drive_m1(input op_t op);
        reg_write_m1  = op.reg_write;
        mem_write_m1  = op.mem_write;
        result_src_m1 = op.result_src;
        funct3_m1     = op.funct3;
        alu_result_m1 = op.alu;
        write_data_m1 = op.wdata;
        pc_plus4_m1   = op.pc4;
        rd_m1         = op.rd;
    endtask

    // Runs one M1 instruction to completion; must be entered at a falling edge.
    task automatic run_op(input op_t op, input exp_t ex, input string nm);
        int total;
        bit is_load, idle_phase, exp_vld;
        total   = ex.stall_cycles + 1;
        is_load = (op.result_src == 2'b01);
        for (int c = 0; c < total; c++) begin
            drive_m1(op);
            idle_phase = !(is_load && ex.req && c > op.ready_delay);
            if (idle_phase) begin
                dif.dmem_req_ready = ex.req ? (c >= op.ready_delay) : 1'($urandom_range(0, 1));
                dif.dmem_rsp_valid = 1'($urandom_range(0, 1));
                dif.dmem_rsp_rdata = $urandom;
            end else begin
                dif.dmem_req_ready = 1'($urandom_range(0, 1));
                dif.dmem_rsp_valid = (c == total - 1);
                dif.dmem_rsp_rdata = (c == total - 1) ? op.rdata : $urandom;
            end
            #1;
            exp_vld = ex.req && idle_phase;
            chk({nm, " stall_m1"}, 32'(stall_m1), 32'(c < ex.stall_cycles));
            chk({nm, " req_valid"}, 32'(dif.dmem_req_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk({nm, " req_addr"}, dif.dmem_req_addr, ex.addr);
                chk({nm, " req_be"}, 32'(dif.dmem_req_be), 32'(ex.be));
                chk({nm, " req_we"}, 32'(dif.dmem_req_we), 32'(op.mem_write));
                if (op.mem_write) chk({nm, " req_wdata"}, dif.dmem_req_wdata, ex.wdata);
            end
            @(negedge clk);
            if (c < ex.stall_cycles) begin
                chk({nm, " bubble reg_write_m2"}, 32'(reg_write_m2), 32'h0);
                chk({nm, " bubble rd_m2"}, 32'(rd_m2), 32'h0);
                chk({nm, " bubble result_src_m2"}, 32'(result_src_m2), 32'h0);
            end else begin
                chk({nm, " reg_write_m2"}, 32'(reg_write_m2), 32'(op.reg_write & ~ex.err));
                chk({nm, " result_src_m2"}, 32'(result_src_m2), 32'(op.result_src));
                chk({nm, " alu_result_m2"}, alu_result_m2, op.alu);
                chk({nm, " read_data_m2"}, read_data_m2, ex.read_data);
                chk({nm, " rd_m2"}, 32'(rd_m2), 32'(op.rd));
                chk({nm, " pc_plus4_m2"}, pc_plus4_m2, op.pc4);
            end
            chk({nm, " misalign_err"}, 32'(misalign_err), 32'((c == total - 1) && ex.err));
        end
    endtask

    vec_t tbl[11];

    initial begin
        op_t  op;
        exp_t ex;
        int   kind;

        tbl[0]  = '{mk(1, 0, 2'b00, 3'b000, 32'h0000_0005, 32'h0,         0, 0, 32'h0),
                    mke(0, 0, 4'h0, 32'h0,         32'h0,         32'h0,         0)};
        tbl[1]  = '{mk(1, 0, 2'b01, 3'b010, 32'h0000_0100, 32'h0,         0, 1, 32'hDEAD_BEEF),
                    mke(2, 1, 4'hF, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 0)};
        tbl[2]  = '{mk(0, 1, 2'b00, 3'b000, 32'h0000_0103, 32'h0000_00A5, 3, 0, 32'h0),
                    mke(3, 1, 4'h8, 32'hA5A5_A5A5, 32'h0000_0100, 32'h0,         0)};
        tbl[3]  = '{mk(1, 0, 2'b01, 3'b000, 32'h0000_0102, 32'h0,         0, 0, 32'h0080_0000),
                    mke(1, 1, 4'h4, 32'h0,         32'h0000_0100, 32'hFFFF_FF80, 0)};
        tbl[4]  = '{mk(1, 0, 2'b01, 3'b100, 32'h0000_0102, 32'h0,         0, 0, 32'h0080_0000),
                    mke(1, 1, 4'h4, 32'h0,         32'h0000_0100, 32'h0000_0080, 0)};
        tbl[5]  = '{mk(1, 0, 2'b01, 3'b010, 32'h0000_0101, 32'h0,         0, 0, 32'h0),
                    mke(0, 0, 4'h0, 32'h0,         32'h0,         32'h0,         1)};
        tbl[6]  = '{mk(0, 1, 2'b00, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 32'h0),
                    mke(1, 1, 4'hC, 32'hBEEF_BEEF, 32'h0000_0100, 32'h0,         0)};
        tbl[7]  = '{mk(1, 0, 2'b01, 3'b001, 32'h0000_0106, 32'h0,         2, 2, 32'h8001_0000),
                    mke(5, 1, 4'hC, 32'h0,         32'h0000_0104, 32'hFFFF_8001, 0)};
        tbl[8]  = '{mk(0, 1, 2'b00, 3'b011, 32'h0000_0200, 32'hCAFE_F00D, 0, 0, 32'h0),
                    mke(0, 1, 4'hF, 32'hCAFE_F00D, 32'h0000_0200, 32'h0,         0)};
        tbl[9]  = '{mk(0, 1, 2'b00, 3'b001, 32'h0000_0101, 32'h0000_1234, 0, 0, 32'h0),
                    mke(0, 0, 4'h0, 32'h0,         32'h0,         32'h0,         1)};
        tbl[10] = '{mk(1, 0, 2'b01, 3'b101, 32'h0000_010A, 32'h0,         0, 3, 32'hF00D_1234),
                    mke(4, 1, 4'hC, 32'h0,         32'h0000_0108, 32'h0000_F00D, 0)};

        // reset state, with a load presented so the request gating is exercised
        rst = 1'b1;
        drive_m1(tbl[1].op);
        dif.dmem_req_ready = 1'b1;
        dif.dmem_rsp_valid = 1'b0;
        dif.dmem_rsp_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset req_valid", 32'(dif.dmem_req_valid), 32'h0);
        chk("reset reg_write_m2", 32'(reg_write_m2), 32'h0);
        chk("reset read_data_m2", read_data_m2, 32'h0);
        chk("reset alu_result_m2", alu_result_m2, 32'h0);
        chk("reset pc_plus4_m2", pc_plus4_m2, 32'h0);
        chk("reset rd_m2", 32'(rd_m2), 32'h0);
        chk("reset misalign_err", 32'(misalign_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].op, tbl[i].ex, $sformatf("tbl%0d", i));
        end

        // reset while waiting for a load response; the late response must be dropped
        drive_m1(mk(1, 0, 2'b01, 3'b010, 32'h0000_0040, 32'h0, 0, 0, 32'h0));
        dif.dmem_req_ready = 1'b1;
        dif.dmem_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwait req_valid", 32'(dif.dmem_req_valid), 32'h0);
        @(negedge clk);
        chk("rstwait reg_write_m2", 32'(reg_write_m2), 32'h0);
        chk("rstwait read_data_m2", read_data_m2, 32'h0);
        chk("rstwait rd_m2", 32'(rd_m2), 32'h0);
        rst = 1'b0;
        drive_m1(mk(0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0));
        dif.dmem_rsp_valid = 1'b1;
        dif.dmem_rsp_rdata = 32'h1234_5678;
        #1;
        chk("rstwait stall_m1", 32'(stall_m1), 32'h0);
        chk("rstwait req_valid idle", 32'(dif.dmem_req_valid), 32'h0);
        @(negedge clk);
        chk("rstwait dropped read_data_m2", read_data_m2, 32'h0);
        chk("rstwait dropped reg_write_m2", 32'(reg_write_m2), 32'h0);
        run_op(tbl[1].op, tbl[1].ex, "rstwait reload");

        // random ops against the transaction model
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 2));
            op = mk(1'($urandom_range(0, 1)), 1'b0, 2'b00, 3'($urandom_range(0, 7)),
                    $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom);
            op.rd = 5'($urandom_range(1, 31));
            if (kind == 1) begin
                op.result_src = 2'b01;
            end else begin
                op.result_src = (2'($urandom_range(0, 2)) == 2'd0) ? 2'b00 : 2'($urandom_range(2, 3));
                op.mem_write  = (kind == 2);
            end
            if ($urandom_range(0, 1) == 1) op.alu[1:0] = 2'b00;
            ex = model(op);
            run_op(op, ex, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 reg_write_m1, mem_write_m1  in  1 each  M1 control, held stable by upstream while stall_m1=1.
REQ-005 result_src_m1  in  2  2'b01 = load; other codes = non-load.
REQ-006 funct3_m1  in  3  [1:0]: 00 byte, 01 half, 10 word; [2]=1 unsigned load.
REQ-007 alu_result_m1, write_data_m1, pc_plus4_m1  in  32 each  address/ALU result, store data, PC+4.
REQ-008 rd_m1  in  5  destination register.
REQ-009 dmem_req_valid  out  1;  dmem_req_ready  in  1;  dmem_req_we  out  1;  dmem_req_addr  out  32;  dmem_req_wdata  out  32;  dmem_req_be  out  4.
REQ-010 dmem_rsp_valid  in  1;  dmem_rsp_rdata  in  32  load response, one word.
REQ-011 stall_m1  out  1  high while the M1 instruction cannot complete this cycle.
REQ-012 misalign_err  out  1  one-cycle registered pulse for a misaligned access.
REQ-013 reg_write_m2, result_src_m2[1:0], alu_result_m2[31:0], read_data_m2[31:0], rd_m2[4:0], pc_plus4_m2[31:0]  out  registered M2 stage.

Function
REQ-014 Memory op = (result_src_m1==2'b01) or mem_write_m1; all other instructions are non-memory ops.
REQ-015 FSM states: IDLE, WAIT_RSP.
REQ-016 IDLE: dmem_req_valid = memory op and aligned; dmem_req_we = mem_write_m1; valid is held until dmem_req_ready.
REQ-017 IDLE, handshake, store: instruction completes; stay IDLE.
REQ-018 IDLE, handshake, load: go to WAIT_RSP.
REQ-019 WAIT_RSP: dmem_req_valid=0; on dmem_rsp_valid the load completes and the FSM returns to IDLE.
REQ-020 dmem_rsp_valid in IDLE SHALL be ignored.
REQ-021 Non-memory op: completes in IDLE with no request; stall_m1=0.
REQ-022 stall_m1 = memory op present and not completing this cycle (combinational).
REQ-023 On the completing edge, M2 registers load the M1 fields.
REQ-024 Load completion: read_data_m2 = extracted, extended response.
REQ-025 Store or non-memory completion: read_data_m2 = 0.
REQ-026 Every non-completing (stall) cycle SHALL write a bubble to M2: reg_write_m2=0, rd_m2=0, result_src_m2=0.
REQ-027 dmem_req_addr = {alu_result_m1[31:2],2'b00}; offset o = alu_result_m1[1:0].
REQ-028 Store byte: be=4'b0001<<o, wdata = byte replicated x4.
REQ-029 Store half: be=4'b0011<<o, wdata = half replicated x2.
REQ-030 Store word: be=4'b1111, wdata = write_data_m1.
REQ-031 Loads: be as for stores; byte/half selected by o from rdata, sign-extended unless funct3_m1[2]=1 (zero-extended).
REQ-032 Misaligned = (half and o[0]) or (word and o!=0).
REQ-033 Misaligned op: no request, completes in one cycle, misalign_err pulses next cycle, reg_write_m2 forced 0.
REQ-034 Latency: non-memory 1 cycle; store >=1 cycle (1 when ready high); load >=2 cycles.
REQ-035 funct3_m1 = 2'b11 SHALL be treated as word.

Reset
REQ-036 rst SHALL force IDLE, all M2 outputs and misalign_err to 0, and dmem_req_valid to 0 in the same cycle.
REQ-037 rst during WAIT_RSP SHALL abandon the load; a later dmem_rsp_valid SHALL be ignored.

Structure
REQ-038 Size codes, result_src encodings and the FSM state enum SHALL live in the shared pipeline package.
REQ-039 Load extraction/extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-040 Add, then lw addr 0x100, ready=1, rsp 2 cycles later = 0xDEADBEEF -> add in M2 next cycle; stall_m1=1 for 2 cycles; read_data_m2=0xDEADBEEF.
REQ-041 sb addr 0x103, data 0x000000A5, ready low 3 cycles -> valid held 4 cycles, be=4'b1000, wdata=0xA5A5A5A5, 3 bubbles in M2.
REQ-042 lb/lbu addr 0x102, rdata 0x00800000 -> read_data_m2 = 0xFFFFFF80 / 0x00000080.
REQ-043 lw addr 0x101 -> no request, misalign_err pulses once, reg_write_m2=0, no stall.
REQ-044 rst in WAIT_RSP, rsp_valid the next cycle -> IDLE, M2 outputs 0, response dropped.
